// File: rtl/rs_decoder_pkg.sv
// Shared constants for the RS(15,11) decoder datapath.
//   GF_W      : default GF(2^4) symbol width.
//   mode_e    : symbol selector mode encodings (SELECT/HOLD/SCAN/CLEAR).
//   sel_width : channel-index width for a given channel count, never below 1.
package rs_decoder_pkg;

    localparam int unsigned GF_W = 4;

    typedef enum logic [1:0] {
        MODE_SELECT = 2'b00,
        MODE_HOLD   = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    // max(1, clog2(n)): a 2-channel selector still needs a 1-bit index.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sel_scan_counter.sv
// Scan pointer for symbol_select_reg: walks channel indices 0..NUM_IN-1 and
// pulses scan_done for one cycle on the step that consumes the last channel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : advance the pointer this cycle (a valid SCAN step)
//   clr        : force pointer to 0 (takes priority over en)
//   ptr        : current channel index
//   scan_done  : registered wrap pulse
module sel_scan_counter
    import rs_decoder_pkg::*;
#(
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [SEL_W-1:0] ptr,
    output logic             scan_done
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_IN - 1);

    // Wrap by explicit compare so non-power-of-two channel counts work.
    logic wrap;
    assign wrap = (ptr == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            scan_done <= 1'b0;
        end else if (clr) begin
            ptr       <= '0;
            scan_done <= 1'b0;
        end else if (en) begin
            ptr       <= wrap ? '0 : ptr + SEL_W'(1);
            scan_done <= wrap;
        end else begin
            scan_done <= 1'b0;
        end
    end

endmodule

// File: rtl/symbol_select_reg.sv
// Registered N-input symbol selector: steers one of NUM_IN symbol streams onto
// a single registered bus, with select, hold, auto-scan and clear modes.
// Optional feature macro: SYMBOL_SELECT_PARITY_EN adds OUT_PAR.
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   IN         : flattened channels, channel k at [k*WIDTH +: WIDTH]
//   SEL        : channel index for SELECT mode
//   MODE       : 00 SELECT, 01 HOLD, 10 SCAN, 11 CLEAR
//   IN_VALID   : qualifies IN in SELECT and SCAN
//   OUT        : registered selected symbol
//   OUT_VALID  : OUT was loaded from a valid input on the previous edge
//   OUT_CH     : channel that produced OUT
//   SCAN_DONE  : one-cycle pulse when the scan pointer wraps
//   OUT_PAR    : (SYMBOL_SELECT_PARITY_EN only) XOR reduction of OUT
module symbol_select_reg
    import rs_decoder_pkg::*;
#(
    parameter  int unsigned WIDTH  = GF_W,
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] IN,
    input  logic [SEL_W-1:0]        SEL,
    input  logic [1:0]              MODE,
    input  logic                    IN_VALID,
    output logic [WIDTH-1:0]        OUT,
    output logic                    OUT_VALID,
    output logic [SEL_W-1:0]        OUT_CH,
    output logic                    SCAN_DONE
`ifdef SYMBOL_SELECT_PARITY_EN
    ,
    output logic                    OUT_PAR
`endif
);

    mode_e            mode;
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] sel_sym;
    logic [WIDTH-1:0] ptr_sym;
    logic             sel_ok;
    logic             load_en;
    logic [WIDTH-1:0] load_sym;
    logic [SEL_W-1:0] load_ch;

    assign mode = mode_e'(MODE);

    // Channel muxes; sel_ok is only set when SEL names a real channel.
    always_comb begin
        sel_sym = '0;
        ptr_sym = '0;
        sel_ok  = 1'b0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (SEL == SEL_W'(k)) begin
                sel_sym = IN[k*WIDTH +: WIDTH];
                sel_ok  = 1'b1;
            end
            if (ptr == SEL_W'(k)) begin
                ptr_sym = IN[k*WIDTH +: WIDTH];
            end
        end
    end

    // What (if anything) gets loaded into the output register this edge.
    always_comb begin
        load_en  = 1'b0;
        load_sym = sel_sym;
        load_ch  = SEL;
        case (mode)
            MODE_SELECT: load_en = IN_VALID & sel_ok;
            MODE_SCAN: begin
                load_en  = IN_VALID;
                load_sym = ptr_sym;
                load_ch  = ptr;
            end
            default: load_en = 1'b0;
        endcase
    end

    sel_scan_counter #(
        .NUM_IN (NUM_IN)
    ) u_scan_counter (
        .clk       (CLK),
        .rst       (RST),
        .en        ((mode == MODE_SCAN) & IN_VALID),
        .clr       (mode == MODE_CLEAR),
        .ptr       (ptr),
        .scan_done (SCAN_DONE)
    );

    // Output register: CLEAR zeroes, a load sets valid, HOLD keeps valid,
    // any other non-loading cycle drops valid while OUT/OUT_CH hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OUT_CH    <= '0;
`ifdef SYMBOL_SELECT_PARITY_EN
            OUT_PAR   <= 1'b0;
`endif
        end else if (mode == MODE_CLEAR) begin
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OUT_CH    <= '0;
`ifdef SYMBOL_SELECT_PARITY_EN
            OUT_PAR   <= 1'b0;
`endif
        end else if (load_en) begin
            OUT       <= load_sym;
            OUT_VALID <= 1'b1;
            OUT_CH    <= load_ch;
`ifdef SYMBOL_SELECT_PARITY_EN
            OUT_PAR   <= ^load_sym;
`endif
        end else if (mode != MODE_HOLD) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_symbol_select_reg.sv
// Self-checking bench for symbol_select_reg: directed vector tables for a
// 4-channel and a 3-channel instance, a mid-scan reset sequence, then random
// stimulus against a behavioural model of the selector.
module tb_symbol_select_reg;
    import rs_decoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [15:0] in4;
    logic [1:0]  sel4, mode4, ch4;
    logic        vld4, ov4, done4;
    logic [3:0]  out4;
    // 3-channel instance
    logic [11:0] in3;
    logic [1:0]  sel3, mode3, ch3;
    logic        vld3, ov3, done3;
    logic [3:0]  out3;
`ifdef SYMBOL_SELECT_PARITY_EN
    logic        par4, par3;
`endif

    symbol_select_reg #(.WIDTH(4), .NUM_IN(4)) dut4 (
        .CLK(clk), .RST(rst), .IN(in4), .SEL(sel4), .MODE(mode4),
        .IN_VALID(vld4), .OUT(out4), .OUT_VALID(ov4), .OUT_CH(ch4),
        .SCAN_DONE(done4)
`ifdef SYMBOL_SELECT_PARITY_EN
        , .OUT_PAR(par4)
`endif
    );

    symbol_select_reg #(.WIDTH(4), .NUM_IN(3)) dut3 (
        .CLK(clk), .RST(rst), .IN(in3), .SEL(sel3), .MODE(mode3),
        .IN_VALID(vld3), .OUT(out3), .OUT_VALID(ov3), .OUT_CH(ch3),
        .SCAN_DONE(done3)
`ifdef SYMBOL_SELECT_PARITY_EN
        , .OUT_PAR(par3)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] sel;
        logic       vld;
        logic [3:0] out;
        logic       ov;
        logic [1:0] ch;
        logic       done;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s, input logic v,
                                input logic [3:0] o, input logic ov, input logic [1:0] c,
                                input logic d);
        vec_t t;
        t.mode = m; t.sel = s; t.vld = v; t.out = o; t.ov = ov; t.ch = c; t.done = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dut(input int d, input string tag, input logic [3:0] o,
                             input logic ov, input logic [1:0] c, input logic dn);
        if (d == 0) begin
            chk({tag, ".out"}, 32'(out4), 32'(o));
            chk({tag, ".valid"}, 32'(ov4), 32'(ov));
            chk({tag, ".ch"}, 32'(ch4), 32'(c));
            chk({tag, ".done"}, 32'(done4), 32'(dn));
`ifdef SYMBOL_SELECT_PARITY_EN
            chk({tag, ".par"}, 32'(par4), 32'(^o));
`endif
        end else begin
            chk({tag, ".out"}, 32'(out3), 32'(o));
            chk({tag, ".valid"}, 32'(ov3), 32'(ov));
            chk({tag, ".ch"}, 32'(ch3), 32'(c));
            chk({tag, ".done"}, 32'(done3), 32'(dn));
`ifdef SYMBOL_SELECT_PARITY_EN
            chk({tag, ".par"}, 32'(par3), 32'(^o));
`endif
        end
    endtask

    task automatic apply(input int d, input vec_t t, input string tag);
        if (d == 0) begin
            mode4 = t.mode; sel4 = t.sel; vld4 = t.vld;
        end else begin
            mode3 = t.mode; sel3 = t.sel; vld3 = t.vld;
        end
        tick();
        check_dut(d, tag, t.out, t.ov, t.ch, t.done);
    endtask

    // Behavioural model state, one slot per instance.
    logic [3:0] m_out [2];
    logic       m_ov  [2];
    logic [1:0] m_ch  [2];
    logic       m_done[2];
    int         m_ptr [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_out[d] = '0; m_ov[d] = 1'b0; m_ch[d] = '0; m_done[d] = 1'b0; m_ptr[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input int n, input logic [1:0] m,
                              input int s, input logic v, input logic [15:0] w);
        m_done[d] = 1'b0;
        case (m)
            2'b00: begin
                if (v && s < n) begin
                    m_out[d] = 4'((w >> (4 * s)) & 16'hF);
                    m_ch[d]  = 2'(s);
                    m_ov[d]  = 1'b1;
                end else m_ov[d] = 1'b0;
            end
            2'b01: ;
            2'b10: begin
                if (v) begin
                    m_out[d]  = 4'((w >> (4 * m_ptr[d])) & 16'hF);
                    m_ch[d]   = 2'(m_ptr[d]);
                    m_ov[d]   = 1'b1;
                    m_done[d] = (m_ptr[d] == n - 1);
                    m_ptr[d]  = (m_ptr[d] + 1) % n;
                end else m_ov[d] = 1'b0;
            end
            default: begin
                m_out[d] = '0; m_ch[d] = '0; m_ov[d] = 1'b0; m_ptr[d] = 0;
            end
        endcase
    endtask

    vec_t v4[19];
    vec_t v3[7];

    initial begin
        // ch3..ch0 = 3,7,C,5
        v4[0]  = mk(MODE_SELECT, 2, 1, 4'h7, 1, 2, 0);
        v4[1]  = mk(MODE_SELECT, 2, 0, 4'h7, 0, 2, 0);
        v4[2]  = mk(MODE_CLEAR,  0, 1, 4'h0, 0, 0, 0);
        v4[3]  = mk(MODE_SCAN,   0, 1, 4'h5, 1, 0, 0);
        v4[4]  = mk(MODE_SCAN,   0, 1, 4'hC, 1, 1, 0);
        v4[5]  = mk(MODE_SCAN,   0, 1, 4'h7, 1, 2, 0);
        v4[6]  = mk(MODE_SCAN,   0, 1, 4'h3, 1, 3, 1);
        v4[7]  = mk(MODE_SCAN,   0, 1, 4'h5, 1, 0, 0);
        v4[8]  = mk(MODE_CLEAR,  3, 0, 4'h0, 0, 0, 0);
        v4[9]  = mk(MODE_SCAN,   0, 1, 4'h5, 1, 0, 0);
        v4[10] = mk(MODE_SCAN,   0, 1, 4'hC, 1, 1, 0);
        v4[11] = mk(MODE_HOLD,   3, 1, 4'hC, 1, 1, 0);
        v4[12] = mk(MODE_HOLD,   0, 0, 4'hC, 1, 1, 0);
        v4[13] = mk(MODE_HOLD,   2, 1, 4'hC, 1, 1, 0);
        v4[14] = mk(MODE_SCAN,   0, 1, 4'h7, 1, 2, 0);
        v4[15] = mk(MODE_SCAN,   0, 0, 4'h7, 0, 2, 0);
        v4[16] = mk(MODE_SCAN,   0, 1, 4'h3, 1, 3, 1);
        v4[17] = mk(MODE_SELECT, 0, 1, 4'h5, 1, 0, 0);
        v4[18] = mk(MODE_SELECT, 1, 1, 4'hC, 1, 1, 0);
        // ch2..ch0 = 7,C,5
        v3[0]  = mk(MODE_SELECT, 1, 1, 4'hC, 1, 1, 0);
        v3[1]  = mk(MODE_SELECT, 3, 1, 4'hC, 0, 1, 0);
        v3[2]  = mk(MODE_CLEAR,  0, 0, 4'h0, 0, 0, 0);
        v3[3]  = mk(MODE_SCAN,   0, 1, 4'h5, 1, 0, 0);
        v3[4]  = mk(MODE_SCAN,   0, 1, 4'hC, 1, 1, 0);
        v3[5]  = mk(MODE_SCAN,   0, 1, 4'h7, 1, 2, 1);
        v3[6]  = mk(MODE_SCAN,   0, 1, 4'h5, 1, 0, 0);

        rst = 1'b1;
        in4 = 16'h37C5; sel4 = '0; mode4 = MODE_HOLD; vld4 = 1'b0;
        in3 = 12'h7C5;  sel3 = '0; mode3 = MODE_HOLD; vld3 = 1'b0;
        #12;
        check_dut(0, "reset4", 4'h0, 1'b0, 2'd0, 1'b0);
        check_dut(1, "reset3", 4'h0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) apply(0, v4[i], $sformatf("v4[%0d]", i));
        mode4 = MODE_HOLD;
        for (int i = 0; i < 7; i++) apply(1, v3[i], $sformatf("v3[%0d]", i));
        mode3 = MODE_HOLD;

        // Mid-scan reset while OUT=0xA and SCAN_DONE is high.
        apply(0, mk(MODE_CLEAR, 0, 0, 4'h0, 0, 0, 0), "pre_rst_clear");
        in4 = 16'hA3C5;
        for (int i = 0; i < 3; i++) apply(0, mk(MODE_SCAN, 0, 1, 4'((16'hA3C5 >> (4 * i)) & 16'hF), 1, 2'(i), 0),
                                          $sformatf("pre_rst_scan%0d", i));
        apply(0, mk(MODE_SCAN, 0, 1, 4'hA, 1, 3, 1), "pre_rst_last");
        #2 rst = 1'b1;
        #1;
        check_dut(0, "async_rst", 4'h0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, mk(MODE_SCAN, 0, 1, 4'h5, 1, 0, 0), "post_rst_scan");

        // Random stimulus against the model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic [1:0] mm [2];
            for (int d = 0; d < 2; d++) begin
                int r;
                r = int'($urandom_range(0, 7));
                mm[d] = (r < 3) ? MODE_SELECT : (r == 3) ? MODE_HOLD :
                        (r < 7) ? MODE_SCAN : MODE_CLEAR;
            end
            mode4 = mm[0]; sel4 = 2'($urandom_range(0, 3)); vld4 = 1'($urandom_range(0, 3) != 0);
            in4 = 16'($urandom);
            mode3 = mm[1]; sel3 = 2'($urandom_range(0, 3)); vld3 = 1'($urandom_range(0, 3) != 0);
            in3 = 12'($urandom);
            model_step(0, 4, mode4, int'(sel4), vld4, in4);
            model_step(1, 3, mode3, int'(sel3), vld3, {4'h0, in3});
            tick();
            check_dut(0, $sformatf("rnd4[%0d]", c), m_out[0], m_ov[0], m_ch[0], m_done[0]);
            check_dut(1, $sformatf("rnd3[%0d]", c), m_out[1], m_ov[1], m_ch[1], m_done[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
